// File: rtl/sif_master.sv
// sif_master: single-command bus master that drives two target ports.
// The X port supports both writes and reads; the W port supports writes only.
// Each accepted command runs to completion before the next is taken; all outputs are registered.
//   clk, rst_b           : clock and asynchronous active-low reset
//   cmd_*                : valid/ready command input (port select, rd/wr, addr, data)
//   xa_*                 : X port strobes, address, write data, and read data return
//   wa_*                 : W port write strobe, address, and write data
//   rsp_*                : valid/ready read response output
//   cmd_err, busy        : illegal-command pulse and activity flag
module sif_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_port,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              xa_wr_s,
  output logic              xa_rd_s,
  output logic [ADDR_W-1:0] xa_addr,
  output logic [DATA_W-1:0] xa_data_wr,
  input  logic [DATA_W-1:0] xa_data_rd,
  output logic              wa_wr_s,
  output logic [ADDR_W-1:0] wa_addr,
  output logic [DATA_W-1:0] wa_data_wr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              cmd_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  // The wait counter is wide enough for RD_LAT up to 4 (RD_LAT-1 <= 3).
  localparam int CNT_W = 3;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              cmd_ready_nxt;
  logic              xa_wr_s_nxt;
  logic              xa_rd_s_nxt;
  logic [ADDR_W-1:0] xa_addr_nxt;
  logic [DATA_W-1:0] xa_data_wr_nxt;
  logic              wa_wr_s_nxt;
  logic [ADDR_W-1:0] wa_addr_nxt;
  logic [DATA_W-1:0] wa_data_wr_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;
  logic              cmd_err_nxt;
  logic              busy_nxt;

  // State and every output are registered together, so each output reflects
  // the state it belongs to in the same cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      xa_wr_s    <= 1'b0;
      xa_rd_s    <= 1'b0;
      xa_addr    <= '0;
      xa_data_wr <= '0;
      wa_wr_s    <= 1'b0;
      wa_addr    <= '0;
      wa_data_wr <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cmd_ready  <= cmd_ready_nxt;
      xa_wr_s    <= xa_wr_s_nxt;
      xa_rd_s    <= xa_rd_s_nxt;
      xa_addr    <= xa_addr_nxt;
      xa_data_wr <= xa_data_wr_nxt;
      wa_wr_s    <= wa_wr_s_nxt;
      wa_addr    <= wa_addr_nxt;
      wa_data_wr <= wa_data_wr_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      cmd_err    <= cmd_err_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    // Defaults: strobes and the error flag are single-cycle pulses; the address,
    // data, and response registers hold their values.
    state_nxt      = state;
    cnt_nxt        = cnt;
    xa_wr_s_nxt    = 1'b0;
    xa_rd_s_nxt    = 1'b0;
    wa_wr_s_nxt    = 1'b0;
    xa_addr_nxt    = xa_addr;
    xa_data_wr_nxt = xa_data_wr;
    wa_addr_nxt    = wa_addr;
    wa_data_wr_nxt = wa_data_wr;
    rsp_valid_nxt  = rsp_valid;
    rsp_data_nxt   = rsp_data;
    cmd_err_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // cmd_ready is the registered flag, so nothing is accepted in the first
        // cycle after reset release.
        if (cmd_valid && cmd_ready) begin
          if (cmd_wr) begin
            // The strobe is launched at the accept edge, so it is high during
            // the WRITE cycle.
            state_nxt = WRITE;
            if (cmd_port) begin
              wa_wr_s_nxt    = 1'b1;
              wa_addr_nxt    = cmd_addr;
              wa_data_wr_nxt = cmd_data;
            end else begin
              xa_wr_s_nxt    = 1'b1;
              xa_addr_nxt    = cmd_addr;
              xa_data_wr_nxt = cmd_data;
            end
          end else if (!cmd_port) begin
            state_nxt   = READ;
            xa_rd_s_nxt = 1'b1;
            xa_addr_nxt = cmd_addr;
          end else begin
            // The W port cannot be read: consume the command and flag it.
            cmd_err_nxt = 1'b1;
          end
        end
      end

      WRITE: begin
        state_nxt = IDLE;
      end

      READ: begin
        // Spend RD_LAT cycles in RD_WAIT; the last one ends on the capture edge.
        state_nxt = RD_WAIT;
        cnt_nxt   = CNT_W'(RD_LAT - 1);
      end

      RD_WAIT: begin
        if (cnt == '0) begin
          rsp_data_nxt  = xa_data_rd;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b0;
      end
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: doc/sif_master.md
SIF_MASTER -- requirements
Module: sif_master

Interface
REQ-001 The module SHALL expose parameter ADDR_W, default 16, meaning address width of both target ports.
REQ-002 The module SHALL expose parameter DATA_W, default 16, meaning data width of both target ports.
REQ-003 The module SHALL expose parameter RD_LAT, default 1, range 1-4, meaning cycles from xa_rd_s assertion to valid xa_data_rd.
REQ-004 Ports SHALL be exactly as follows:
  clk  in  1  single clock; all state updates on rising edge
  rst_b  in  1  asynchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_port  in  1  0 = X port, 1 = W port
  cmd_wr  in  1  1 = write, 0 = read
  cmd_addr  in  ADDR_W  target address
  cmd_data  in  DATA_W  write data
  xa_wr_s  out  1  X write strobe
  xa_rd_s  out  1  X read strobe
  xa_addr  out  ADDR_W  X address
  xa_data_wr  out  DATA_W  X write data
  xa_data_rd  in  DATA_W  X read data
  wa_wr_s  out  1  W write strobe
  wa_addr  out  ADDR_W  W address
  wa_data_wr  out  DATA_W  W write data
  rsp_valid  out  1  read response available
  rsp_data  out  DATA_W  read response data
  rsp_ready  in  1  response consumed when high with rsp_valid
  cmd_err  out  1  one-cycle pulse: illegal command rejected
  busy  out  1  high whenever state is not IDLE

Function
REQ-005 States SHALL be IDLE, WRITE, READ, RD_WAIT, RESP; all outputs registered.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid and cmd_ready both 1.
REQ-007 Accepted write (cmd_wr=1): IDLE->WRITE; in WRITE the selected port's wr_s SHALL be 1 for exactly one cycle with addr/data_wr = captured cmd_addr/cmd_data; WRITE->IDLE.
REQ-008 Accepted X read (cmd_port=0, cmd_wr=0): IDLE->READ; xa_rd_s SHALL be 1 for exactly one cycle (cycle N) with xa_addr = cmd_addr.
REQ-009 READ->RD_WAIT; xa_data_rd SHALL be captured on the rising edge ending cycle N+RD_LAT, then RD_WAIT->RESP.
REQ-010 In RESP, rsp_valid SHALL be 1 and rsp_data stable until the edge where rsp_ready=1; then RESP->IDLE.
REQ-011 rsp_ready already 1 on entry to RESP SHALL complete the response in one cycle.
REQ-012 W read (cmd_port=1, cmd_wr=0) SHALL be accepted, issue no strobe, pulse cmd_err for one cycle, and remain in IDLE.
REQ-013 At most one strobe among xa_wr_s, xa_rd_s, wa_wr_s SHALL be 1 in any cycle.
REQ-014 Outside its strobe cycle, a port's addr and data_wr SHALL hold their last driven value (0 after reset).
REQ-015 Minimum spacing SHALL be two cycles per write and RD_LAT+3 cycles per read with rsp_ready tied high.
REQ-016 Inputs cmd_* SHALL be sampled only at acceptance; changes while busy SHALL have no effect.

Reset
REQ-017 rst_b=0 SHALL asynchronously force state IDLE and all outputs to 0 except cmd_ready, which SHALL be 0 during reset and 1 from the first edge after release.
REQ-018 Reset mid-transaction SHALL abort it: no further strobe, pending response discarded, no rsp_valid after release.
REQ-019 Reset SHALL be applied and released at any cycle; no command SHALL be accepted while rst_b=0.

Verification
REQ-020 X write addr=0x0010 data=0xA5A5 -> xa_wr_s high one cycle, one cycle after accept, xa_addr=0x0010, xa_data_wr=0xA5A5; cmd_ready back to 1 next cycle.
REQ-021 W write addr=0x0003 data=0x1234 -> wa_wr_s high one cycle with matching addr/data; xa_* strobes stay 0.
REQ-022 X read addr=0x0020, model returns 0xBEEF RD_LAT cycles after xa_rd_s, rsp_ready low 3 cycles -> rsp_valid held 3+ cycles, rsp_data=0xBEEF, drops after rsp_ready.
REQ-023 W read command -> cmd_err one-cycle pulse, no strobe, busy stays 0.
REQ-024 rst_b low during RD_WAIT, released 2 cycles later -> all outputs 0 immediately, no rsp_valid afterwards; next X write completes normally.
REQ-025 Back-to-back random mix of 200 commands with random rsp_ready -> scoreboard matches every strobe and response; REQ-013 checked every cycle.
